// File: rtl/tqvp_htfab_palette_vga_pkg.sv
// Shared constants for the palette VGA peripheral: 1024x768@60 timing,
// register offsets, register bit positions and the palette reset value.
package vga_pkg;

  localparam logic [10:0] H_VIS        = 11'd1024;
  localparam logic [10:0] H_FP         = 11'd24;
  localparam logic [10:0] H_SYNC       = 11'd136;
  localparam logic [10:0] H_BP         = 11'd160;
  localparam logic [10:0] H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam logic [10:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [10:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0]  V_VIS        = 10'd768;
  localparam logic [9:0]  V_FP         = 10'd3;
  localparam logic [9:0]  V_SYNC       = 10'd6;
  localparam logic [9:0]  V_BP         = 10'd29;
  localparam logic [9:0]  V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  V_SYNC_START = V_VIS + V_FP;
  localparam logic [9:0]  V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [5:0] OFF_PALETTE = 6'h30;
  localparam logic [5:0] OFF_SCROLL  = 6'h34;
  localparam logic [5:0] OFF_CTRL    = 6'h38;
  localparam logic [5:0] OFF_STATUS  = 6'h3C;

  localparam int CTRL_VBL_EN    = 0;
  localparam int CTRL_LINE_EN   = 1;
  localparam int CTRL_CMP_LSB   = 16;
  localparam int STAT_VBL_PEND  = 0;
  localparam int STAT_LINE_PEND = 1;
  localparam int STAT_LINE_LSB  = 16;

  localparam logic [31:0] PALETTE_RESET = 32'h3F3F3F00;
  localparam logic [31:0] PALETTE_MASK  = 32'h3F3F3F3F;

  // RRGGBB entry plus syncs onto the PMOD order {hs, B0, G0, R0, vs, B1, G1, R1}.
  function automatic logic [7:0] pal_to_uo(input logic [5:0] rgb, input logic hs,
                                           input logic vs);
    return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
  endfunction

endpackage

// File: rtl/tqvp_htfab_palette_vga_if.sv
// TinyQV peripheral bus as seen by the palette VGA block.
// Write: data_write_n==2'b10 for one cycle commits data_in; read: data_read_n==2'b10 is
// answered by a one-cycle data_ready in the next cycle, data_out holds until the next read.
interface tqvp_htfab_palette_vga_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (output address, data_in, data_write_n, data_read_n,
                  input  data_out, data_ready);
  modport slave  (input  address, data_in, data_write_n, data_read_n,
                  output data_out, data_ready);
endinterface

// File: rtl/tqvp_htfab_palette_vga_timing.sv
// Pixel/line counters for 1024x768@60 with active-low syncs, blanking and
// single-cycle strobes at x=0 of the vblank line and of the compare line.
module vga_timing_param
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  i_line_cmp,
  output logic [10:0] o_x,
  output logic [9:0]  o_line,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic        o_vblank_start,
  output logic        o_line_match
);

  logic [10:0] r_x;
  logic [9:0]  r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_line <= '0;
    end else if (r_x == H_TOTAL - 11'd1) begin
      r_x    <= '0;
      r_line <= (r_line == V_TOTAL - 10'd1) ? '0 : r_line + 10'd1;
    end else begin
      r_x <= r_x + 11'd1;
    end
  end

  assign o_x            = r_x;
  assign o_line         = r_line;
  assign o_hsync        = !((r_x >= H_SYNC_START) && (r_x < H_SYNC_END));
  assign o_vsync        = !((r_line >= V_SYNC_START) && (r_line < V_SYNC_END));
  assign o_blank        = (r_x >= H_VIS) || (r_line >= V_VIS);
  assign o_vblank_start = (r_x == '0) && (r_line == V_VIS);
  assign o_line_match   = (r_x == '0) && (r_line == i_line_cmp);

endmodule

// File: rtl/tqvp_htfab_palette_vga.sv
// Palette VGA peripheral: framebuffer rows with vertical scroll, 1/2-bpp palette
// lookup, registered PMOD output, register file and maskable interrupts.
module tqvp_htfab_palette_vga
  import vga_pkg::*;
#(
  parameter int COLS      = 32,
  parameter int BPP       = 1,
  parameter int ROWS      = 12,
  parameter int ROW_LINES = 64
)
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     ui_in,
  output logic [7:0]                     uo_out,
  tqvp_htfab_palette_vga_if.slave        bus,
  output logic                           user_interrupt
);

  localparam int          PIX_W    = 1024 / COLS;
  localparam int          FB_LINES = ROWS * ROW_LINES;
  localparam logic [31:0] PIX_MASK = (BPP == 2) ? 32'h3 : 32'h1;

  generate
    if (!((COLS == 8 || COLS == 16 || COLS == 32) && (BPP == 1 || BPP == 2) &&
          (COLS * BPP <= 32) && (ROWS >= 1) && (ROWS <= 12) && (ROW_LINES >= 1) &&
          (FB_LINES <= 768))) begin : g_bad_params
      $error("tqvp_htfab_palette_vga: illegal COLS/BPP/ROWS/ROW_LINES combination");
    end
  endgenerate

  logic [31:0] r_fb [ROWS];
  logic [31:0] r_pal;
  logic [3:0]  r_scroll;
  logic [1:0]  r_en;
  logic [9:0]  r_cmp;
  logic [1:0]  r_pend;
  logic        r_irq;
  logic        r_ready;
  logic [31:0] r_data;
  logic [7:0]  r_uo;

  logic [10:0] w_x;
  logic [9:0]  w_line;
  logic        w_hsync, w_vsync, w_blank, w_vblank_start, w_line_match;

  vga_timing_param u_timing (
    .clk            (clk),
    .rst            (rst),
    .i_line_cmp     (r_cmp),
    .o_x            (w_x),
    .o_line         (w_line),
    .o_hsync        (w_hsync),
    .o_vsync        (w_vsync),
    .o_blank        (w_blank),
    .o_vblank_start (w_vblank_start),
    .o_line_match   (w_line_match)
  );

  // Both the row and the scroll are below ROWS, so one subtraction wraps the sum.
  logic [4:0]  w_col, w_row_sum, w_word;
  logic [3:0]  w_row;
  logic [5:0]  w_bit;
  logic [31:0] w_fb_word;
  logic [1:0]  w_idx;
  logic [5:0]  w_entry, w_colour;

  assign w_col     = 5'(32'(w_x) / PIX_W);
  assign w_row     = 4'(32'(w_line) / ROW_LINES);
  assign w_row_sum = {1'b0, w_row} + {1'b0, r_scroll};
  assign w_word    = (w_row_sum >= 5'(ROWS)) ? w_row_sum - 5'(ROWS) : w_row_sum;
  assign w_bit     = 6'(w_col) * 6'(BPP);
  assign w_idx     = 2'((w_fb_word >> w_bit) & PIX_MASK);

  always_comb begin
    w_fb_word = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (w_word == 5'(i)) w_fb_word = r_fb[i];
    end
  end

  always_comb begin
    case (w_idx)
      2'd0:    w_entry = r_pal[5:0];
      2'd1:    w_entry = r_pal[13:8];
      2'd2:    w_entry = r_pal[21:16];
      default: w_entry = r_pal[29:24];
    endcase
  end

  assign w_colour = w_blank                      ? 6'h00 :
                    (32'(w_line) >= FB_LINES)    ? r_pal[5:0] : w_entry;

  always_ff @(posedge clk) begin
    if (rst) r_uo <= 8'h88;
    else     r_uo <= pal_to_uo(w_colour, w_hsync, w_vsync);
  end

  logic        w_wr, w_rd, w_accept, w_wr_stat, w_wr_ctrl;
  logic [3:0]  w_widx;
  logic [1:0]  w_pend_set, w_pend_clr, w_pend_nxt, w_en_nxt;
  logic [31:0] w_rdata;

  assign w_widx    = bus.address[5:2];
  assign w_wr      = (bus.data_write_n == 2'b10);
  assign w_rd      = (bus.data_read_n == 2'b10);
  assign w_accept  = w_rd && !r_ready;
  assign w_wr_stat = w_wr && (w_widx == OFF_STATUS[5:2]);
  assign w_wr_ctrl = w_wr && (w_widx == OFF_CTRL[5:2]);

  // A hardware event in the same cycle as a W1C clear keeps the pending bit set.
  assign w_pend_set = {w_line_match, w_vblank_start};
  assign w_pend_clr = w_wr_stat ? {bus.data_in[STAT_LINE_PEND], bus.data_in[STAT_VBL_PEND]}
                                : 2'b00;
  assign w_pend_nxt = w_pend_set | (r_pend & ~w_pend_clr);
  assign w_en_nxt   = w_wr_ctrl ? {bus.data_in[CTRL_LINE_EN], bus.data_in[CTRL_VBL_EN]} : r_en;

  always_ff @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (w_wr && (w_widx == 4'(i))) r_fb[i] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pal    <= PALETTE_RESET;
      r_scroll <= '0;
      r_en     <= '0;
      r_cmp    <= '0;
      r_pend   <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_widx == OFF_PALETTE[5:2])) r_pal <= bus.data_in & PALETTE_MASK;
      if (w_wr && (w_widx == OFF_SCROLL[5:2]))  r_scroll <= 4'(32'(bus.data_in[3:0]) % ROWS);
      if (w_wr_ctrl) r_cmp <= bus.data_in[CTRL_CMP_LSB +: 10];
      r_en   <= w_en_nxt;
      r_pend <= w_pend_nxt;
      r_irq  <= |(w_pend_nxt & w_en_nxt);
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (w_widx == 4'(i)) w_rdata = r_fb[i];
    end
    case ({w_widx, 2'b00})
      OFF_PALETTE: w_rdata = r_pal;
      OFF_SCROLL:  w_rdata[3:0] = r_scroll;
      OFF_CTRL: begin
        w_rdata[CTRL_VBL_EN]          = r_en[0];
        w_rdata[CTRL_LINE_EN]         = r_en[1];
        w_rdata[CTRL_CMP_LSB +: 10]   = r_cmp;
      end
      OFF_STATUS: begin
        w_rdata[STAT_VBL_PEND]        = r_pend[0];
        w_rdata[STAT_LINE_PEND]       = r_pend[1];
        w_rdata[STAT_LINE_LSB +: 10]  = w_line;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      r_ready <= w_accept;
      if (w_accept) r_data <= w_rdata;
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, ui_in, bus.address[1:0]};

  assign uo_out          = r_uo;
  assign user_interrupt  = r_irq;
  assign bus.data_out    = r_data;
  assign bus.data_ready  = r_ready;

endmodule

// File: tb/tb_tqvp_htfab_palette_vga.sv
// Directed bench for the palette VGA peripheral: a default 1-bpp instance and a
// 2-bpp/16-column/2-row instance share one clock and reset.
module tb_tqvp_htfab_palette_vga;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo1, uo2;
  logic       irq1, irq2;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  tqvp_htfab_palette_vga_if b1 ();
  tqvp_htfab_palette_vga_if b2 ();

  tqvp_htfab_palette_vga u_dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo1),
    .bus            (b1),
    .user_interrupt (irq1)
  );

  tqvp_htfab_palette_vga #(.COLS(16), .BPP(2), .ROWS(2), .ROW_LINES(4)) u_dut2 (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo2),
    .bus            (b2),
    .user_interrupt (irq2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // cyc equals the DUT counter position (line*1344 + x) while rst is low
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Output after posedge k shows the pixel of counter position k-1.
  task automatic check_px(input string tag, input bit sel, input int line, input int x,
                          input logic [7:0] exp);
    wait_cyc(line * 1344 + x + 1);
    check(tag, 32'(sel ? uo2 : uo1), 32'(exp));
  endtask

  task automatic wr1(input logic [5:0] a, input logic [31:0] d);
    b1.address = a; b1.data_in = d; b1.data_write_n = 2'b10;
    @(negedge clk);
    b1.data_write_n = 2'b11;
  endtask

  task automatic wr2(input logic [5:0] a, input logic [31:0] d);
    b2.address = a; b2.data_in = d; b2.data_write_n = 2'b10;
    @(negedge clk);
    b2.data_write_n = 2'b11;
  endtask

  task automatic rd1(input string tag, input logic [5:0] a, input logic [31:0] exp);
    b1.address = a; b1.data_read_n = 2'b10;
    @(negedge clk);
    b1.data_read_n = 2'b11;
    check({tag, "_rdy"}, 32'(b1.data_ready), 32'd1);
    check(tag, b1.data_out, exp);
    @(negedge clk);
    check({tag, "_rdy_drop"}, 32'(b1.data_ready), 32'd0);
  endtask

  task automatic rd2(input string tag, input logic [5:0] a, input logic [31:0] exp);
    b2.address = a; b2.data_read_n = 2'b10;
    @(negedge clk);
    b2.data_read_n = 2'b11;
    check({tag, "_rdy"}, 32'(b2.data_ready), 32'd1);
    check(tag, b2.data_out, exp);
    @(negedge clk);
    check({tag, "_rdy_drop"}, 32'(b2.data_ready), 32'd0);
  endtask

  initial begin
    int lows;
    rst = 1'b1; ui_in = 8'h00;
    b1.address = '0; b1.data_in = '0; b1.data_write_n = 2'b11; b1.data_read_n = 2'b11;
    b2.address = '0; b2.data_in = '0; b2.data_write_n = 2'b11; b2.data_read_n = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_uo1", 32'(uo1), 32'h88);
    check("rst_uo2", 32'(uo2), 32'h88);
    check("rst_rdy1", 32'(b1.data_ready), 32'd0);
    check("rst_irq1", 32'(irq1), 32'd0);
    check("rst_irq2", 32'(irq2), 32'd0);
    rst = 1'b0;

    // configuration during line 0
    rd1("pal_rst", 6'h30, 32'h3F3F3F00);
    wr1(6'h00, 32'h0000_0001);
    wr1(6'h30, 32'h3F3F_3000);
    wr2(6'h00, 32'h0000_000E);
    wr2(6'h04, 32'h0000_0005);
    wr2(6'h30, 32'h3F30_0C03);
    rd2("pal2", 6'h30, 32'h3F30_0C03);

    // line 1: 1-bpp red first column; 2-bpp e2, e3 then e0
    check_px("l1_x0_d1",    1'b0, 1, 0,    8'h99);
    check_px("l1_x0_d2",    1'b1, 1, 0,    8'h99);
    check_px("l1_x31_d1",   1'b0, 1, 31,   8'h99);
    check_px("l1_x32_d1",   1'b0, 1, 32,   8'h88);
    check_px("l1_x63_d1",   1'b0, 1, 63,   8'h88);
    check_px("l1_x63_d2",   1'b1, 1, 63,   8'h99);
    check_px("l1_x64_d2",   1'b1, 1, 64,   8'hFF);
    check_px("l1_x127_d2",  1'b1, 1, 127,  8'hFF);
    check_px("l1_x128_d2",  1'b1, 1, 128,  8'hCC);
    check_px("l1_blank_d1", 1'b0, 1, 1030, 8'h88);
    check_px("l1_hs_d1",    1'b0, 1, 1048, 8'h08);

    lows = 0;
    for (int k = 2 * 1344 + 1; k <= 3 * 1344; k++) begin
      wait_cyc(k);
      if (uo1[7] == 1'b0) lows++;
    end
    check("hsync_lows", 32'(lows), 32'd136);

    // row 1 of the 2-row instance, then scroll wraps it back to row 0, then border
    check_px("l4_row1_d2", 1'b1, 4, 0, 8'hAA);
    wr2(6'h34, 32'h0000_0003);
    rd2("scroll_mod", 6'h34, 32'h0000_0001);
    check_px("l5_scr_x0_d2",  1'b1, 5, 0,  8'h99);
    check_px("l5_scr_x64_d2", 1'b1, 5, 64, 8'hFF);
    check_px("l8_border_d2",  1'b1, 8, 0,  8'hCC);
    rd2("unmapped_2c", 6'h2C, 32'h0);
    rd2("unmapped_08", 6'h08, 32'h0);

    // LINE_CMP resets to 0, so LINE_PEND was set at line 0
    wait_cyc(10 * 1344 + 100);
    rd1("stat_l10", 6'h3C, 32'h000A_0002);
    check("irq_masked", 32'(irq1), 32'd0);
    wr1(6'h3C, 32'h0000_0002);
    rd1("stat_w1c", 6'h3C, 32'h000A_0000);
    wr1(6'h38, 32'h0014_0003);
    rd1("ctrl_rb", 6'h38, 32'h0014_0003);
    check("irq_no_pend", 32'(irq1), 32'd0);

    wait_cyc(20 * 1344);
    check("irq_at_event", 32'(irq1), 32'd0);
    @(negedge clk);
    check("irq_after_event", 32'(irq1), 32'd1);
    wr1(6'h3C, 32'h0000_0002);
    check("irq_after_w1c", 32'(irq1), 32'd0);
    wait_cyc(25 * 1344 + 5);
    check("irq_stays_low", 32'(irq1), 32'd0);
    rd1("stat_l25", 6'h3C, 32'h0019_0000);

    // W1C landing in the same cycle as the line-30 event
    wr1(6'h38, 32'h001E_0003);
    wait_cyc(30 * 1344);
    wr1(6'h3C, 32'h0000_0002);
    check("race_irq", 32'(irq1), 32'd1);
    rd1("race_stat", 6'h3C, 32'h001E_0002);
    wr1(6'h3C, 32'h0000_0002);
    check("race_clear_irq", 32'(irq1), 32'd0);

    // held read request acknowledges every other cycle
    b1.address = 6'h30; b1.data_read_n = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("held_rdy_%0d", i), 32'(b1.data_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    check("held_data", b1.data_out, 32'h3F3F_3000);
    b1.data_read_n = 2'b11;
    @(negedge clk);

    // reset arriving with a read request drops the acknowledge
    b1.address = 6'h30; b1.data_read_n = 2'b10; rst = 1'b1;
    @(negedge clk);
    check("rst_read_rdy", 32'(b1.data_ready), 32'd0);
    check("rst_read_uo", 32'(uo1), 32'h88);
    b1.data_read_n = 2'b11;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
